draw_text_box: RTL

//  Parametrised text overlay on the VGA timing/rgb pipeline. Holds a COLS x ROWS

---
 rtl/draw_text_box.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/draw_text_box.sv
// Text overlay stage: COLS x ROWS character buffer, external 8x16 font ROM, 3-cycle pipeline.
// Optional feature macro: DRAW_TEXT_TRANSPARENT_EN (clear glyph bits pass rgb_in through).
module draw_text_box #(
    parameter int          X_POS      = 200,
    parameter int          Y_POS      = 400,
    parameter int          COLS       = 30,
    parameter int          ROWS       = 2,
    parameter int          SCALE_LOG2 = 0,
    parameter logic [11:0] FG_RGB     = 12'hFFF,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter int          ADDR_W     = $clog2(COLS*ROWS)
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic [10:0]       hcount_in,
    input  logic [10:0]       vcount_in,
    input  logic              hsync_in,
    input  logic              hblnk_in,
    input  logic              vsync_in,
    input  logic              vblnk_in,
    input  logic [11:0]       rgb_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [7:0]        char_code,
    output logic [3:0]        char_line,
    input  logic [7:0]        char_pixels,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              hblnk_out,
    output logic              vsync_out,
    output logic              vblnk_out,
    output logic [11:0]       rgb_out
);

    localparam int              DEPTH   = COLS * ROWS;
    localparam logic [11:0]     X_LO    = 12'(X_POS);
    localparam logic [11:0]     X_HI    = 12'(X_POS + ((COLS * 8) << SCALE_LOG2));
    localparam logic [11:0]     Y_LO    = 12'(Y_POS);
    localparam logic [11:0]     Y_HI    = 12'(Y_POS + ((ROWS * 16) << SCALE_LOG2));
    localparam logic [10:0]     X_OFF   = 11'(X_POS);
    localparam logic [10:0]     Y_OFF   = 11'(Y_POS);
    localparam logic [10:0]     COLS_W  = 11'(COLS);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    // Buffer powers up holding spaces; reset never touches it.
    logic [7:0] text_mem [0:DEPTH-1] = '{default: 8'h20};

    logic [10:0]       dx, dy, col, row;
    logic [ADDR_W-1:0] rd_addr;
    logic              win_d;
    logic [2:0]        bit_d;
    logic [3:0]        line_d;

    always_comb begin
        dx      = hcount_in - X_OFF;
        dy      = vcount_in - Y_OFF;
        col     = dx >> (3 + SCALE_LOG2);
        row     = dy >> (4 + SCALE_LOG2);
        rd_addr = ADDR_W'(row * COLS_W + col);
        win_d   = ({1'b0, hcount_in} >= X_LO) && ({1'b0, hcount_in} < X_HI) &&
                  ({1'b0, vcount_in} >= Y_LO) && ({1'b0, vcount_in} < Y_HI);
        bit_d   = 3'd7 - dx[SCALE_LOG2 +: 3];
        line_d  = dy[SCALE_LOG2 +: 4];
    end

    // Host write: single-cycle strobe, no handshake; out-of-range addresses dropped.
    always_ff @(posedge pclk) begin
        if (wr_en && ({1'b0, wr_addr} < DEPTH_W))
            text_mem[wr_addr] <= wr_data;
    end

    logic [7:0] rd_data_q;

    // Read-first: a same-cycle write to this address is seen on the following read.
    always_ff @(posedge pclk) begin
        if (rst)
            rd_data_q <= 8'h00;
        else if (win_d)
            rd_data_q <= text_mem[rd_addr];
    end

    logic        s1_win_q, s2_win_q;
    logic [2:0]  s1_bit_q, s2_bit_q;
    logic [3:0]  s1_line_q;
    logic [10:0] s1_hcount_q, s1_vcount_q, s2_hcount_q, s2_vcount_q;
    logic        s1_hsync_q, s1_hblnk_q, s1_vsync_q, s1_vblnk_q;
    logic        s2_hsync_q, s2_hblnk_q, s2_vsync_q, s2_vblnk_q;
    logic [11:0] s1_rgb_q, s2_rgb_q;
    logic [11:0] rgb_d;

    always_comb begin
        rgb_d = s2_rgb_q;
        if (s2_win_q && !s2_hblnk_q && !s2_vblnk_q) begin
            if (char_pixels[s2_bit_q])
                rgb_d = FG_RGB;
            else
`ifdef DRAW_TEXT_TRANSPARENT_EN
                rgb_d = s2_rgb_q;
`else
                rgb_d = BG_RGB;
`endif
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            s1_win_q    <= 1'b0;
            s1_bit_q    <= 3'd0;
            s1_line_q   <= 4'd0;
            s1_hcount_q <= 11'd0;
            s1_vcount_q <= 11'd0;
            s1_hsync_q  <= 1'b0;
            s1_hblnk_q  <= 1'b0;
            s1_vsync_q  <= 1'b0;
            s1_vblnk_q  <= 1'b0;
            s1_rgb_q    <= 12'd0;
            s2_win_q    <= 1'b0;
            s2_bit_q    <= 3'd0;
            s2_hcount_q <= 11'd0;
            s2_vcount_q <= 11'd0;
            s2_hsync_q  <= 1'b0;
            s2_hblnk_q  <= 1'b0;
            s2_vsync_q  <= 1'b0;
            s2_vblnk_q  <= 1'b0;
            s2_rgb_q    <= 12'd0;
            char_code   <= 8'd0;
            char_line   <= 4'd0;
            hcount_out  <= 11'd0;
            vcount_out  <= 11'd0;
            hsync_out   <= 1'b0;
            hblnk_out   <= 1'b0;
            vsync_out   <= 1'b0;
            vblnk_out   <= 1'b0;
            rgb_out     <= 12'd0;
        end else begin
            s1_win_q    <= win_d;
            s1_bit_q    <= bit_d;
            s1_line_q   <= line_d;
            s1_hcount_q <= hcount_in;
            s1_vcount_q <= vcount_in;
            s1_hsync_q  <= hsync_in;
            s1_hblnk_q  <= hblnk_in;
            s1_vsync_q  <= vsync_in;
            s1_vblnk_q  <= vblnk_in;
            s1_rgb_q    <= rgb_in;

            s2_win_q    <= s1_win_q;
            s2_bit_q    <= s1_bit_q;
            s2_hcount_q <= s1_hcount_q;
            s2_vcount_q <= s1_vcount_q;
            s2_hsync_q  <= s1_hsync_q;
            s2_hblnk_q  <= s1_hblnk_q;
            s2_vsync_q  <= s1_vsync_q;
            s2_vblnk_q  <= s1_vblnk_q;
            s2_rgb_q    <= s1_rgb_q;
            // ROM address holds its last in-window value outside the box.
            if (s1_win_q) begin
                char_code <= rd_data_q;
                char_line <= s1_line_q;
            end

            hcount_out  <= s2_hcount_q;
            vcount_out  <= s2_vcount_q;
            hsync_out   <= s2_hsync_q;
            hblnk_out   <= s2_hblnk_q;
            vsync_out   <= s2_vsync_q;
            vblnk_out   <= s2_vblnk_q;
            rgb_out     <= rgb_d;
        end
    end

endmodule
